// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder, one mux-based full-adder cell reused per cycle (option: SERIAL_ADD_OVF_EN)
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic [1:0]       sel;
  logic [3:0]       sum_mux;
  logic [3:0]       carry_mux;
  logic             sum_bit;
  logic             carry_bit;

  // Full-adder cell: two 4:1 muxes indexed by the current operand LSBs
  always_comb begin
    sel       = {a_sh_q[0], b_sh_q[0]};
    sum_mux   = {carry_q, ~carry_q, ~carry_q, carry_q};
    carry_mux = {1'b1, carry_q, carry_q, 1'b0};
    sum_bit   = sum_mux[sel];
    carry_bit = carry_mux[sel];
  end

  // Next-state: load on start from IDLE/DONE, shift one bit per RUN cycle, commit on the last bit
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    psum_d  = psum_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          psum_d  = '0;
          carry_d = cin;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        psum_d  = {sum_bit, psum_q[WIDTH-1:1]};
        carry_d = carry_bit;
        cnt_d   = cnt_q + CW'(1);
        busy_d  = 1'b1;
        if (cnt_q == LAST_BIT) begin
          // carry_q here is the carry into the MSB, carry_bit the carry out of it
          sum_d   = {sum_bit, psum_q[WIDTH-1:1]};
          cout_d  = carry_bit;
`ifdef SERIAL_ADD_OVF_EN
          ovf_d   = carry_q ^ carry_bit;
`endif
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      psum_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      psum_q  <= psum_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule
